// File: rtl/seg_scan_if.sv
// seg_scan_if: load/value request and busy/done/bcd result bundle for seg_scan_driver
interface seg_scan_if;
  logic        load;
  logic [7:0]  value;
  logic        busy;
  logic        done;
  logic [11:0] bcd;
  modport master (output load, value, input busy, done, bcd);
  modport slave (input load, value, output busy, done, bcd);
endinterface

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: double-dabble binary-to-BCD converter with multiplexed 3-digit display scan
module seg_scan_driver #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  seg_scan_if.slave   bus,
  output logic [7:0]  digit_code,
  output logic [2:0]  anode
);
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, COMMIT = 2'd2;
  logic [1:0]  state_q, state_d;
  logic [7:0]  sr_q, sr_d;
  logic [11:0] work_q, work_d, adj;
  logic [2:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic [11:0] bcd_q, bcd_d;
  logic [15:0] rcnt_q, rcnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  code_q, code_d;
  logic [2:0]  an_q, an_d;
  logic [3:0]  nib;
  logic        blank, tc;
  always_comb begin
    adj = {work_q[11:8] >= 4'd5 ? work_q[11:8] + 4'd3 : work_q[11:8],
           work_q[7:4]  >= 4'd5 ? work_q[7:4]  + 4'd3 : work_q[7:4],
           work_q[3:0]  >= 4'd5 ? work_q[3:0]  + 4'd3 : work_q[3:0]};
    state_d = state_q;
    sr_d = sr_q;
    work_d = work_q;
    cnt_d = cnt_q;
    bcd_d = bcd_q;
    done_d = 1'b0;
    busy_d = state_q != IDLE;
    if (state_q == IDLE && bus.load) begin
      state_d = SHIFT;
      sr_d = bus.value;
      work_d = '0;
      cnt_d = '0;
    end else if (state_q == SHIFT) begin
      {work_d, sr_d} = {adj, sr_q} << 1;
      cnt_d = cnt_q + 3'd1;
      state_d = cnt_q == 3'd7 ? COMMIT : SHIFT;
    end else if (state_q == COMMIT) begin
      bcd_d = work_q;
      done_d = 1'b1;
      state_d = IDLE;
    end
  end
  // Scan path only reads the committed bcd, so conversions never disturb it
  always_comb begin
    tc = rcnt_q == 16'(REFRESH_DIV - 1);
    rcnt_d = tc ? '0 : rcnt_q + 16'd1;
    idx_d = tc ? (idx_q == 2'd2 ? 2'd0 : idx_q + 2'd1) : idx_q;
    nib = idx_q == 2'd2 ? bcd_q[11:8] : idx_q == 2'd1 ? bcd_q[7:4] : bcd_q[3:0];
    blank = (idx_q == 2'd2 && bcd_q[11:8] == 4'd0) || (idx_q == 2'd1 && bcd_q[11:4] == 8'd0);
    code_d = blank ? 8'd0 : {4'd0, nib};
    an_d = blank ? 3'b111 : idx_q == 2'd2 ? 3'b011 : idx_q == 2'd1 ? 3'b101 : 3'b110;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q <= '0;
      work_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      bcd_q <= '0;
      rcnt_q <= '0;
      idx_q <= '0;
      code_q <= '0;
      an_q <= 3'b110;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      work_q <= work_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      bcd_q <= bcd_d;
      rcnt_q <= rcnt_d;
      idx_q <= idx_d;
      code_q <= code_d;
      an_q <= an_d;
    end
  end
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.bcd = bcd_q;
  assign digit_code = code_q;
  assign anode = an_q;
endmodule
